// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares the single word port of `mem` among NREQ engines.
// It supports a bounded lock so one engine can run read-modify-write sequences.
module mem_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int WORD_WIDTH = 16,
  parameter int LOCK_MAX   = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              we,
  input  logic [NREQ-1:0]              lock,
  input  logic [NREQ*ADDR_WIDTH-1:0]   addr,
  input  logic [NREQ*WORD_WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              rvalid,
  output logic [WORD_WIDTH-1:0]        rdata,
  output logic [NREQ-1:0]              err,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  output logic                         mem_wr_en,
  output logic [WORD_WIDTH-1:0]        mem_data_in,
  input  logic [WORD_WIDTH-1:0]        mem_data_out
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);
  localparam logic [CNTW-1:0] LCNT_LAST = CNTW'(LOCK_MAX - 1);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  state_t                r_state, w_nextState;
  logic [IDXW-1:0]       r_ptr, w_nextPtr;
  logic [IDXW-1:0]       r_owner, w_nextOwner;
  logic [CNTW-1:0]       r_lcnt, w_nextLcnt;
  logic [NREQ-1:0]       r_rvalid, r_err;
  logic [WORD_WIDTH-1:0] r_rdata;

  logic                  w_found, w_grant, w_bad;
  logic [IDXW-1:0]       w_win, w_scanIdx;
  logic [ADDR_WIDTH-1:0] w_selAddr;
  logic [WORD_WIDTH-1:0] w_selData;
  logic [NREQ-1:0]       w_oneHot;

  function automatic logic [IDXW-1:0] nextIdx(input logic [IDXW-1:0] i);
    nextIdx = (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // While locked only the owner may win; otherwise scan from ptr with wrap-around.
  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_scanIdx = r_ptr;
    if (r_state == ST_LOCKED) begin
      w_found = req[r_owner];
      w_win   = r_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_found && req[w_scanIdx]) begin
          w_found = 1'b1;
          w_win   = w_scanIdx;
        end
        w_scanIdx = nextIdx(w_scanIdx);
      end
    end
  end

  assign w_grant   = w_found & ~reset;
  assign w_selAddr = addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_selData = wdata[int'(w_win)*WORD_WIDTH +: WORD_WIDTH];
  // Odd addresses and the last byte cannot hold a full word, so they are rejected.
  assign w_bad     = w_selAddr[0] | (w_selAddr == {ADDR_WIDTH{1'b1}});
  assign w_oneHot  = NREQ'(1) << w_win;

  assign gnt         = w_grant ? w_oneHot : '0;
  assign mem_address = w_grant ? w_selAddr : '0;
  assign mem_data_in = w_grant ? w_selData : '0;
  assign mem_wr_en   = w_grant & we[w_win] & ~w_bad;

  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    w_nextOwner = r_owner;
    w_nextLcnt  = r_lcnt;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_grant) begin
          w_nextPtr = nextIdx(w_win);
          if (lock[w_win]) begin
            w_nextState = ST_LOCKED;
            w_nextOwner = w_win;
            w_nextLcnt  = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (r_lcnt != LCNT_LAST) w_nextLcnt = r_lcnt + 1'b1;
        if ((r_lcnt == LCNT_LAST) || !req[r_owner] || (w_grant && !lock[r_owner])) begin
          w_nextState = ST_UNLOCKED;
          w_nextPtr   = nextIdx(r_owner);
          w_nextLcnt  = '0;
        end
      end
      default: w_nextState = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_UNLOCKED;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_lcnt   <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_nextState;
      r_ptr    <= w_nextPtr;
      r_owner  <= w_nextOwner;
      r_lcnt   <= w_nextLcnt;
      r_rvalid <= (w_grant && !we[w_win] && !w_bad) ? w_oneHot : '0;
      r_err    <= (w_grant && w_bad) ? w_oneHot : '0;
      if (w_grant && w_bad) begin
        r_rdata <= '0;
      end else if (w_grant && !we[w_win]) begin
        r_rdata <= mem_data_out;
      end
    end
  end

  // Pulses already registered for the cycle in which reset rises are dropped.
  assign rvalid = r_rvalid & {NREQ{~reset}};
  assign err    = r_err & {NREQ{~reset}};
  assign rdata  = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences, with a
// scoreboard queue for the read/err results that appear one cycle after each grant.
module tb_mem_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 11;
  localparam int DW   = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, we, lock;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   gnt, rvalid, err;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     mem_address;
  logic              mem_wr_en;
  logic [DW-1:0]     mem_data_in, mem_data_out;

  logic [DW-1:0] memArr [1024];
  logic [DW-1:0] shadow [1024];

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] req, we, lock;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [NREQ-1:0] expGnt;
  } vec_t;

  typedef struct {
    logic [NREQ-1:0] rv, er;
    logic [DW-1:0]   rd;
  } sb_t;

  sb_t  sbQ[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .WORD_WIDTH(DW), .LOCK_MAX(64)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .err(err), .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Word-wide memory with combinational read, standing in for `mem`.
  always @(posedge clock) begin
    if (mem_wr_en) memArr[mem_address[AW-1:1]] <= mem_data_in;
  end
  assign mem_data_out = memArr[mem_address[AW-1:1]];

  function automatic vec_t mk(input logic rst, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] w,
                              input logic [NREQ-1:0] lk, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [NREQ-1:0] g);
    vec_t v;
    v.rst = rst; v.req = rq; v.we = w; v.lock = lk; v.a = a; v.d = d; v.expGnt = g;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle, checks the combinational grant path and last cycle's results.
  task automatic applyStimulus(input vec_t v);
    sb_t           expOut, nxt;
    int            g;
    logic          granted, bad, expWr;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    reset = v.rst; req = v.req; we = v.we; lock = v.lock;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]  = v.a + AW'(16 * i);
      wdata[i*DW +: DW] = v.d ^ DW'(16'h1111 * i);
    end
    #3;
    if (sbQ.size() > 0) expOut = sbQ.pop_front();
    else expOut = '{rv: '0, er: '0, rd: '0};
    if (v.rst) expOut = '{rv: '0, er: '0, rd: '0};
    checkOutput("rvalid", 32'(rvalid), 32'(expOut.rv));
    checkOutput("err", 32'(err), 32'(expOut.er));
    if (expOut.rv != 0 || expOut.er != 0) checkOutput("rdata", 32'(rdata), 32'(expOut.rd));

    granted = (v.expGnt != 0);
    g = 0;
    for (int i = 0; i < NREQ; i++) if (v.expGnt[i]) g = i;
    sa    = v.a + AW'(16 * g);
    sd    = v.d ^ DW'(16'h1111 * g);
    bad   = sa[0] | (sa == {AW{1'b1}});
    expWr = granted & v.we[g] & ~bad;
    checkOutput("gnt", 32'(gnt), 32'(v.expGnt));
    checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(expWr));
    checkOutput("mem_address", 32'(mem_address), granted ? 32'(sa) : 32'd0);
    checkOutput("mem_data_in", 32'(mem_data_in), granted ? 32'(sd) : 32'd0);

    nxt.rv = (granted && !v.we[g] && !bad) ? v.expGnt : '0;
    nxt.er = (granted && bad) ? v.expGnt : '0;
    nxt.rd = bad ? '0 : shadow[sa[AW-1:1]];
    if (expWr) shadow[sa[AW-1:1]] = sd;
    sbQ.push_back(nxt);
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      memArr[i] = '0;
      shadow[i] = '0;
    end
    reset = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;

    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 11'h688, 16'h1234, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 11'h688, 16'h0000, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 11'h000, 16'h0000, 4'b0000));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 11'h600, 16'h0000, 4'b1000));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 11'h700, 16'hA5A0, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 11'h700, 16'hA5A0, 4'b0010));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 11'h700, 16'hA5A0, 4'b0100));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 11'h700, 16'hA5A0, 4'b1000));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 11'h700, 16'h0000, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 11'h700, 16'h0000, 4'b0010));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 11'h700, 16'h0000, 4'b0100));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 11'h700, 16'h0000, 4'b1000));
    vecs.push_back(mk(0, 4'b0110, 4'b0000, 4'b0010, 11'h67A, 16'h0000, 4'b0010));
    vecs.push_back(mk(0, 4'b0110, 4'b0000, 4'b0010, 11'h67A, 16'h0000, 4'b0010));
    vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0000, 11'h67A, 16'h5550, 4'b0010));
    vecs.push_back(mk(0, 4'b0111, 4'b0000, 4'b0000, 11'h67A, 16'h0000, 4'b0100));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000, 11'h67A, 16'h0000, 4'b0010));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 11'h600, 16'h0000, 4'b1000));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 11'h600, 16'h0000, 4'b0000));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 11'h600, 16'h0000, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 11'h689, 16'hDEAD, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 11'h7FF, 16'hBEEF, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 11'h688, 16'h0000, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 11'h7FE, 16'h0000, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 11'h700, 16'h0000, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 11'h7FF, 16'h0000, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 11'h000, 16'h0000, 4'b0000));

    @(posedge clock);
    #1;
    applyStimulus(mk(1, 4'b0001, 4'b0001, 4'b0000, 11'h688, 16'h1234, 4'b0000));
    applyStimulus(mk(1, 4'b0001, 4'b0001, 4'b0000, 11'h688, 16'h1234, 4'b0000));
    checkOutput("rdataReset", 32'(rdata), 32'd0);

    foreach (vecs[n]) applyStimulus(vecs[n]);

    // Lock held by req3 past LOCK_MAX while req0 waits for the forced release.
    applyStimulus(mk(0, 4'b1000, 4'b0000, 4'b1000, 11'h600, 16'h0000, 4'b1000));
    for (int k = 0; k < 64; k++)
      applyStimulus(mk(0, 4'b1001, 4'b0000, 4'b1000, 11'h600, 16'h0000, 4'b1000));
    applyStimulus(mk(0, 4'b1001, 4'b0000, 4'b1000, 11'h600, 16'h0000, 4'b0001));
    for (int k = 0; k < 4; k++)
      applyStimulus(mk(0, 4'b1000, 4'b0000, 4'b1000, 11'h600, 16'h0000, 4'b1000));
    applyStimulus(mk(0, 4'b1000, 4'b0000, 4'b0000, 11'h600, 16'h0000, 4'b1000));

    // Reset while req1 owns the lock with a read in flight.
    applyStimulus(mk(0, 4'b0010, 4'b0000, 4'b0010, 11'h6F0, 16'h0000, 4'b0010));
    applyStimulus(mk(0, 4'b0010, 4'b0000, 4'b0010, 11'h6F0, 16'h0000, 4'b0010));
    applyStimulus(mk(1, 4'b0011, 4'b0000, 4'b0000, 11'h6F0, 16'h0000, 4'b0000));
    applyStimulus(mk(0, 4'b0011, 4'b0000, 4'b0000, 11'h6F0, 16'h0000, 4'b0001));
    applyStimulus(mk(0, 4'b0011, 4'b0000, 4'b0000, 11'h6F0, 16'h0000, 4'b0010));
    applyStimulus(mk(0, 4'b0000, 4'b0000, 4'b0000, 11'h000, 16'h0000, 4'b0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
